// File: rtl/top_pkg.sv
// Shared top-level definitions: chunk sizing and the west ping-pong read FSM states.
package top_pkg;

    localparam int TOP_CHUNK_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } pp_rd_state_e;

    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pp_rd_skid.sv
// Two-entry skid FIFO for the ping-pong read path; entry 0 is always the head,
// so the head data and valid come straight from registers.
module pp_rd_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [1:0]   occ
);

    logic [W-1:0] entry0_r;
    logic [W-1:0] entry1_r;
    logic [1:0]   cnt_r;

    // Storage and occupancy update; the caller never pushes into a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= {W{1'b0}};
            entry1_r <= {W{1'b0}};
            cnt_r    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        entry0_r <= push_data;
                        cnt_r    <= 2'd1;
                    end else if (cnt_r == 2'd1) begin
                        entry1_r <= push_data;
                        cnt_r    <= 2'd2;
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                2'b01: begin
                    if (cnt_r != 2'd0) begin
                        entry0_r <= entry1_r;
                        entry1_r <= {W{1'b0}};
                        cnt_r    <= cnt_r - 2'd1;
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        entry0_r <= entry1_r;
                        entry1_r <= push_data;
                    end else begin
                        entry0_r <= push_data;
                        cnt_r    <= 2'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign head_data  = entry0_r;
    assign head_valid = (cnt_r != 2'd0);
    assign occ        = cnt_r;

endmodule

// File: rtl/ping_pong_rd_ctrl_w.sv
// Read-side controller for the WEST ping-pong buffer: reads each full bank REPEAT
// times and streams 2 words/beat. Optional perf counters under PP_RD_PERF_EN.
module ping_pong_rd_ctrl_w
    import top_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_CORES_A   = 2,
    parameter int NUM_CORES_B   = 1,
    parameter int COL_X         = 16,
    parameter int TOTAL_INPUT_W = 2,
    parameter int REPEAT        = 4,
    localparam int MODULE_WIDTH = WIDTH * TOP_CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
    localparam int ADDR_WIDTH   = $clog2(COL_X * TOTAL_INPUT_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_bank_done,
    input  logic                      wr_bank_idx,
    output logic [1:0]                rd_bank_free,
    output logic                      bank0_ena,
    output logic                      bank0_enb,
    output logic [ADDR_WIDTH-1:0]     bank0_addra,
    output logic [ADDR_WIDTH-1:0]     bank0_addrb,
    input  logic [MODULE_WIDTH-1:0]   bank0_douta,
    input  logic [MODULE_WIDTH-1:0]   bank0_doutb,
    output logic                      bank1_ena,
    output logic                      bank1_enb,
    output logic [ADDR_WIDTH-1:0]     bank1_addra,
    output logic [ADDR_WIDTH-1:0]     bank1_addrb,
    input  logic [MODULE_WIDTH-1:0]   bank1_douta,
    input  logic [MODULE_WIDTH-1:0]   bank1_doutb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*MODULE_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      out_pass_last,
`ifdef PP_RD_PERF_EN
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_wait_cnt,
`endif
    output logic                      err_overflow
);

    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int SKID_W = 2 * MODULE_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] K_LAST    = ADDR_WIDTH'(COL_X - 1);
    localparam logic [ADDR_WIDTH-1:0] B_BASE    = ADDR_WIDTH'(COL_X);
    localparam logic [PASS_W-1:0]     PASS_LAST = PASS_W'(REPEAT - 1);

    pp_rd_state_e          state_r;
    pp_rd_state_e          state_s;
    logic                  cur_bank_r;
    logic [1:0]            full_r;
    logic [1:0]            full_next_s;
    logic                  ovf_s;
    logic [ADDR_WIDTH-1:0] k_r;
    logic [PASS_W-1:0]     pass_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic                  inflight_plast_r;
    logic                  err_overflow_r;
    logic [1:0]            rd_bank_free_r;
    logic                  issue_s;
    logic [1:0]            load_s;
    logic [1:0]            occ_s;
    logic                  pop_s;
    logic                  skid_valid_s;
    logic [SKID_W-1:0]     head_s;
    logic [SKID_W-1:0]     push_data_s;

    // Bank-full bookkeeping: a new fill wins over a same-cycle release.
    always_comb begin
        full_next_s = full_r;
        ovf_s       = 1'b0;
        if (state_r == RELEASE) begin
            full_next_s = full_next_s & ~bank_onehot(cur_bank_r);
        end else begin
            full_next_s = full_next_s;
        end
        if (wr_bank_done) begin
            full_next_s = full_next_s | bank_onehot(wr_bank_idx);
            ovf_s       = full_r[wr_bank_idx];
        end else begin
            ovf_s       = 1'b0;
        end
    end

    // Next state and read issue; a pop this cycle frees a slot so issue can continue.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        load_s  = occ_s + {1'b0, inflight_r};
        case (state_r)
            IDLE: begin
                if (full_r[cur_bank_r]) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if ((load_s < 2'd2) || pop_s) begin
                    issue_s = 1'b1;
                    if ((k_r == K_LAST) && (pass_r == PASS_LAST)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if ((occ_s == 2'd0) && !inflight_r) begin
                    state_s = RELEASE;
                end else begin
                    state_s = DRAIN;
                end
            end
            RELEASE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Read port drive: only the active bank sees enables, idle addresses sit at zero.
    always_comb begin
        bank0_ena   = 1'b0;
        bank0_enb   = 1'b0;
        bank1_ena   = 1'b0;
        bank1_enb   = 1'b0;
        bank0_addra = {ADDR_WIDTH{1'b0}};
        bank0_addrb = {ADDR_WIDTH{1'b0}};
        bank1_addra = {ADDR_WIDTH{1'b0}};
        bank1_addrb = {ADDR_WIDTH{1'b0}};
        if (issue_s && !cur_bank_r) begin
            bank0_ena   = 1'b1;
            bank0_enb   = 1'b1;
            bank0_addra = k_r;
            bank0_addrb = k_r + B_BASE;
        end else if (issue_s && cur_bank_r) begin
            bank1_ena   = 1'b1;
            bank1_enb   = 1'b1;
            bank1_addra = k_r;
            bank1_addrb = k_r + B_BASE;
        end else begin
            bank0_ena   = 1'b0;
        end
    end

    // FSM, bank pointer, status flags and release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cur_bank_r     <= 1'b0;
            full_r         <= 2'b00;
            err_overflow_r <= 1'b0;
            rd_bank_free_r <= 2'b00;
        end else begin
            state_r        <= state_s;
            full_r         <= full_next_s;
            err_overflow_r <= err_overflow_r | ovf_s;
            rd_bank_free_r <= (state_s == RELEASE) ? bank_onehot(cur_bank_r) : 2'b00;
            cur_bank_r     <= (state_r == RELEASE) ? ~cur_bank_r : cur_bank_r;
        end
    end

    // Word and pass counters advance once per issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r    <= {ADDR_WIDTH{1'b0}};
            pass_r <= {PASS_W{1'b0}};
        end else if (state_r == RELEASE) begin
            k_r    <= {ADDR_WIDTH{1'b0}};
            pass_r <= {PASS_W{1'b0}};
        end else if (issue_s) begin
            if (k_r == K_LAST) begin
                k_r    <= {ADDR_WIDTH{1'b0}};
                pass_r <= (pass_r == PASS_LAST) ? {PASS_W{1'b0}} : pass_r + {{(PASS_W-1){1'b0}}, 1'b1};
            end else begin
                k_r    <= k_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            k_r    <= k_r;
        end
    end

    // Flags ride alongside the read through the one-cycle BRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r       <= 1'b0;
            inflight_last_r  <= 1'b0;
            inflight_plast_r <= 1'b0;
        end else begin
            inflight_r       <= issue_s;
            inflight_last_r  <= issue_s && (k_r == K_LAST);
            inflight_plast_r <= issue_s && (k_r == K_LAST) && (pass_r == PASS_LAST);
        end
    end

    // Returning BRAM word pair of the active bank plus its flags.
    always_comb begin
        push_data_s = {inflight_plast_r, inflight_last_r, bank0_doutb, bank0_douta};
        if (cur_bank_r) begin
            push_data_s = {inflight_plast_r, inflight_last_r, bank1_doutb, bank1_douta};
        end else begin
            push_data_s = {inflight_plast_r, inflight_last_r, bank0_doutb, bank0_douta};
        end
    end

    assign pop_s = skid_valid_s && out_ready;

    pp_rd_skid #(
        .W (SKID_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_r),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (skid_valid_s),
        .occ        (occ_s)
    );

    assign out_valid     = skid_valid_s;
    assign out_data      = head_s[2*MODULE_WIDTH-1:0];
    assign out_last      = head_s[2*MODULE_WIDTH];
    assign out_pass_last = head_s[2*MODULE_WIDTH+1];
    assign rd_bank_free  = rd_bank_free_r;
    assign err_overflow  = err_overflow_r;

`ifdef PP_RD_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_wait_r;

    // Saturating stall and bank-wait cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
            perf_wait_r  <= 32'd0;
        end else begin
            if (skid_valid_s && !out_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if ((state_r == IDLE) && !full_r[cur_bank_r] && (perf_wait_r != 32'hFFFF_FFFF)) begin
                perf_wait_r <= perf_wait_r + 32'd1;
            end else begin
                perf_wait_r <= perf_wait_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_r;
    assign perf_wait_cnt  = perf_wait_r;
`endif

endmodule

// File: tb/tb_ping_pong_rd_ctrl_w.sv
// Directed bench for ping_pong_rd_ctrl_w with COL_X=4, REPEAT=2 and an
// address-tagged BRAM model.
module tb_ping_pong_rd_ctrl_w;

    localparam int COL_X  = 4;
    localparam int REPEAT = 2;
    localparam int MW     = 16 * top_pkg::TOP_CHUNK_SIZE * 2 * 1;
    localparam int AW     = 3;

    logic            clk;
    logic            rst_n;
    logic            wr_bank_done;
    logic            wr_bank_idx;
    logic [1:0]      rd_bank_free;
    logic            bank0_ena, bank0_enb, bank1_ena, bank1_enb;
    logic [AW-1:0]   bank0_addra, bank0_addrb, bank1_addra, bank1_addrb;
    logic [MW-1:0]   bank0_douta, bank0_doutb, bank1_douta, bank1_doutb;
    logic            out_valid;
    logic            out_ready;
    logic [2*MW-1:0] out_data;
    logic            out_last;
    logic            out_pass_last;
    logic            err_overflow;
`ifdef PP_RD_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] free_q[$];

    ping_pong_rd_ctrl_w #(
        .WIDTH(16), .NUM_CORES_A(2), .NUM_CORES_B(1),
        .COL_X(COL_X), .TOTAL_INPUT_W(2), .REPEAT(REPEAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_bank_done(wr_bank_done), .wr_bank_idx(wr_bank_idx),
        .rd_bank_free(rd_bank_free),
        .bank0_ena(bank0_ena), .bank0_enb(bank0_enb),
        .bank0_addra(bank0_addra), .bank0_addrb(bank0_addrb),
        .bank0_douta(bank0_douta), .bank0_doutb(bank0_doutb),
        .bank1_ena(bank1_ena), .bank1_enb(bank1_enb),
        .bank1_addra(bank1_addra), .bank1_addrb(bank1_addrb),
        .bank1_douta(bank1_douta), .bank1_doutb(bank1_doutb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_pass_last(out_pass_last),
`ifdef PP_RD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_wait_cnt(perf_wait_cnt),
`endif
        .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MW-1:0] pat(input logic b, input logic [AW-1:0] a);
        logic [MW-1:0] v;
        v = {MW{1'b0}};
        v[15:0]      = {4'hA, 3'b000, b, 5'b00000, a};
        v[MW-1-:16]  = {4'h5, 3'b000, b, 5'b00000, a};
        return v;
    endfunction

    function automatic logic [2*MW-1:0] exp_data(input logic b, input int k);
        return {pat(b, AW'(k + COL_X)), pat(b, AW'(k))};
    endfunction

    // BRAM model, read latency 1
    always @(posedge clk) begin
        if (bank0_ena) bank0_douta <= pat(1'b0, bank0_addra);
        if (bank0_enb) bank0_doutb <= pat(1'b0, bank0_addrb);
        if (bank1_ena) bank1_douta <= pat(1'b1, bank1_addra);
        if (bank1_enb) bank1_doutb <= pat(1'b1, bank1_addrb);
    end

    always @(negedge clk) begin
        if (rd_bank_free != 2'b00) free_q.push_back(rd_bank_free);
    end

    task automatic chk_i(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [2*MW-1:0] act, input logic [2*MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int ctrl_outs();
        return int'({out_valid, out_last, out_pass_last, rd_bank_free,
                     bank0_ena, bank0_enb, bank1_ena, bank1_enb,
                     bank0_addra, bank0_addrb, bank1_addra, bank1_addrb, err_overflow});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; wr_bank_done = 1'b0; wr_bank_idx = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        free_q.delete();
    endtask

    task automatic pulse_done(input logic idx);
        wr_bank_done = 1'b1; wr_bank_idx = idx;
        @(posedge clk); #1 wr_bank_done = 1'b0;
    endtask

    // Follows the beat stream: data/flags, hold-while-stalled and optional gap check.
    task automatic stream_check(input int nbeats, input logic b_first, input bit rnd,
                                input bit nobubble, input int budget);
        int i = 0;
        int cyc = 0;
        int last_acc = -1;
        bit stalled = 1'b0;
        logic [2*MW-1:0] held = {2*MW{1'b0}};
        logic bank;
        int j, k, p;
        while (i < nbeats && cyc < budget) begin
            @(negedge clk);
            if (out_valid) begin
                bank = (i < 8) ? b_first : ~b_first;
                j = i % 8; k = j % 4; p = j / 4;
                chk_w("stream data", out_data, exp_data(bank, k));
                chk_i("stream flags", int'({out_last, out_pass_last}),
                      int'({k == 3, (k == 3) && (p == REPEAT - 1)}));
                if (stalled) chk_w("stall stable", out_data, held);
                if (out_ready) begin
                    if (nobubble && j != 0) chk_i("no bubble gap", cyc - last_acc, 1);
                    last_acc = cyc; i++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = out_data;
                end
            end else if (stalled) begin
                chk_i("valid held while stalled", int'(out_valid), 1);
                stalled = 1'b0;
            end
            @(posedge clk);
            #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        chk_i("stream beat count", i, nbeats);
    endtask

    typedef struct {
        logic done; logic idx; logic ready;
        logic e_valid; int e_k; logic e_last; logic e_plast; logic e_ena0; logic [1:0] e_free;
    } vec_t;

    function automatic vec_t mk(logic d, logic ix, logic r, logic v, int k,
                                logic l, logic pl, logic e0, logic [1:0] f);
        vec_t t;
        t.done = d; t.idx = ix; t.ready = r; t.e_valid = v; t.e_k = k;
        t.e_last = l; t.e_plast = pl; t.e_ena0 = e0; t.e_free = f;
        return t;
    endfunction

    vec_t vt[15];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        bit found;
        // cycle-exact single-bank sequence from reset, out_ready=1
        vt[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        vt[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        vt[2]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 2'b00);
        vt[3]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 2'b00);
        vt[4]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 2'b00);
        vt[5]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 2'b00);
        vt[6]  = mk(0, 0, 1, 1, 2, 0, 0, 1, 2'b00);
        vt[7]  = mk(0, 0, 1, 1, 3, 1, 0, 1, 2'b00);
        vt[8]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 2'b00);
        vt[9]  = mk(0, 0, 1, 1, 1, 0, 0, 1, 2'b00);
        vt[10] = mk(0, 0, 1, 1, 2, 0, 0, 0, 2'b00);
        vt[11] = mk(0, 0, 1, 1, 3, 1, 1, 0, 2'b00);
        vt[12] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        vt[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b01);
        vt[14] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);

        // 1: reset state, then table
        do_reset();
        chk_i("reset ctrl outputs", ctrl_outs(), 0);
        chk_w("reset out_data", out_data, {2*MW{1'b0}});
        for (int i = 0; i < 15; i++) begin
            wr_bank_done = vt[i].done; wr_bank_idx = vt[i].idx; out_ready = vt[i].ready;
            @(negedge clk);
            chk_i($sformatf("vec%0d ctrl", i),
                  int'({out_valid, out_last, out_pass_last, bank0_ena, bank0_enb, bank1_ena, bank1_enb, rd_bank_free}),
                  int'({vt[i].e_valid, vt[i].e_last, vt[i].e_plast, vt[i].e_ena0, vt[i].e_ena0, 2'b00, vt[i].e_free}));
            if (vt[i].e_valid) chk_w($sformatf("vec%0d data", i), out_data, exp_data(1'b0, vt[i].e_k));
            @(posedge clk); #1;
        end

        // 2: both banks back-to-back
        do_reset();
        out_ready = 1'b1;
        wr_bank_done = 1'b1; wr_bank_idx = 1'b0;
        @(posedge clk); #1 wr_bank_idx = 1'b1;
        @(posedge clk); #1 wr_bank_done = 1'b0;
        stream_check(16, 1'b0, 1'b0, 1'b1, 200);
        repeat (6) @(posedge clk);
        #1 chk_i("t2 free count", free_q.size(), 2);
        if (free_q.size() == 2) chk_i("t2 free order", int'({free_q[0], free_q[1]}), 6);

        // 3: random backpressure
        do_reset();
        pulse_done(1'b0);
        stream_check(8, 1'b0, 1'b1, 1'b0, 400);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_i("t3 no extra beat", int'(out_valid), 0);
        chk_i("t3 free count", free_q.size(), 1);

        // 4: overflow is sticky
        do_reset();
        out_ready = 1'b1;
        wr_bank_done = 1'b1; wr_bank_idx = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_i("t4 no ovf after first done", int'(err_overflow), 0);
        @(posedge clk); #1 wr_bank_done = 1'b0;
        @(negedge clk);
        chk_i("t4 ovf after second done", int'(err_overflow), 1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk_i("t4 ovf sticky", int'(err_overflow), 1);
        chk_i("t4 single release", free_q.size(), 1);

        // 5: only bank1 filled -> wait for bank0
        do_reset();
        out_ready = 1'b1;
        pulse_done(1'b1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid || bank0_ena || bank0_enb || bank1_ena || bank1_enb) bad++;
        end
        chk_i("t5 idle while bank0 empty", bad, 0);
        @(posedge clk); #1;
        pulse_done(1'b0);
        stream_check(16, 1'b0, 1'b0, 1'b1, 200);

        // 6: async reset at beat 3 of pass 0
        do_reset();
        out_ready = 1'b1;
        pulse_done(1'b0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_data == exp_data(1'b0, 2)) found = 1'b1;
        end
        chk_i("t6 reached beat 3", int'(found), 1);
        rst_n = 1'b0;
        #1 chk_i("t6 outputs cleared by reset", ctrl_outs(), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk_i("t6 no release on reset", free_q.size(), 0);
        pulse_done(1'b0);
        stream_check(8, 1'b0, 1'b0, 1'b1, 100);
        repeat (6) @(posedge clk);
        #1 chk_i("t6 release after restart", free_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
